fma_dot_engine: RTL and testbench



---
 rtl/fma_dot_engine_if.sv | 20 ++
 rtl/fma_dot_engine.sv | 107 ++++++++++
 tb/tb_fma_dot_engine.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fma_dot_engine_if.sv
// rtl/fma_dot_engine_if.sv - operand/result bundle between HPS PIOs and fma_dot_engine
interface fma_dot_engine_if;
    logic [7:0]  a_0, a_1, a_2, a_3, a_4, a_5, a_6, a_7;
    logic [7:0]  b_0, b_1, b_2, b_3, b_4, b_5, b_6, b_7;
    logic [18:0] result;
    logic        busy;
    logic        done;

    modport master (
        output a_0, a_1, a_2, a_3, a_4, a_5, a_6, a_7,
        output b_0, b_1, b_2, b_3, b_4, b_5, b_6, b_7,
        input  result, busy, done
    );

    modport slave (
        input  a_0, a_1, a_2, a_3, a_4, a_5, a_6, a_7,
        input  b_0, b_1, b_2, b_3, b_4, b_5, b_6, b_7,
        output result, busy, done
    );
endinterface

// File: rtl/fma_dot_engine.sv
// rtl/fma_dot_engine.sv - settle-then-accumulate 8-term dot product; FMA_SIGNED_EN selects signed operands
module fma_dot_engine #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    fma_dot_engine_if.slave  io
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2
    } state_t;

    state_t       state, state_nx;
    logic [127:0] live, snap, prev;
    logic [7:0]   cnt;
    logic [2:0]   idx;
    logic [18:0]  acc, prod, sum, result_q;
    logic [7:0]   op_a, op_b;
    logic         done_q;

    // Packed layout: a_0 in the low byte, b_7 in the high byte.
    assign live = {io.b_7, io.b_6, io.b_5, io.b_4, io.b_3, io.b_2, io.b_1, io.b_0,
                   io.a_7, io.a_6, io.a_5, io.a_4, io.a_3, io.a_2, io.a_1, io.a_0};

    assign op_a = snap[{1'b0, idx, 3'b000} +: 8];
    assign op_b = snap[{1'b1, idx, 3'b000} +: 8];

`ifdef FMA_SIGNED_EN
    logic signed [15:0] prod16;
    assign prod16 = $signed({{8{op_a[7]}}, op_a}) * $signed({{8{op_b[7]}}, op_b});
    assign prod   = {{3{prod16[15]}}, prod16};
`else
    logic [15:0] prod16;
    assign prod16 = {8'b0, op_a} * {8'b0, op_b};
    assign prod   = {3'b000, prod16};
`endif

    assign sum = (idx == 3'd0) ? prod : acc + prod;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (live != snap) state_nx = SETTLE;
            SETTLE:  if (live == prev && cnt == CNT_LAST) state_nx = ACCUM;
            ACCUM:   if (idx == 3'd7) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            snap     <= '0;
            prev     <= '0;
            cnt      <= '0;
            idx      <= '0;
            acc      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (live != snap) begin
                        prev <= live;
                        cnt  <= '0;
                    end
                end
                SETTLE: begin
                    // Any fresh PIO write restarts the stability window.
                    if (live != prev) begin
                        prev <= live;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        snap <= live;
                        idx  <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ACCUM: begin
                    acc <= sum;
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        result_q <= sum;
                        done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.result = result_q;
    assign io.done   = done_q;
    assign io.busy   = (state != IDLE);

endmodule

// File: tb/tb_fma_dot_engine.sv
// tb/tb_fma_dot_engine.sv - directed self-checking bench for fma_dot_engine
module tb_fma_dot_engine;

    logic clk_clk = 1'b0;
    logic reset_reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fma_dot_engine_if io();

    fma_dot_engine #(.STABLE_CYCLES(4)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .io          (io)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] v);
        case (i)
            0:  io.a_0 = v;  1:  io.a_1 = v;  2:  io.a_2 = v;  3:  io.a_3 = v;
            4:  io.a_4 = v;  5:  io.a_5 = v;  6:  io.a_6 = v;  7:  io.a_7 = v;
            8:  io.b_0 = v;  9:  io.b_1 = v;  10: io.b_2 = v;  11: io.b_3 = v;
            12: io.b_4 = v;  13: io.b_5 = v;  14: io.b_6 = v;  default: io.b_7 = v;
        endcase
    endtask

    task automatic set_all(input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < 8; i++) begin
            set_op(i, av);
            set_op(i + 8, bv);
        end
    endtask

    task automatic run(input int n, output int pulses, output int busy_cycles);
        pulses = 0;
        busy_cycles = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (io.done) pulses++;
            if (io.busy) busy_cycles++;
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!io.done && cyc < limit);
    endtask

    int pulses, busy_cycles, cyc, bad;
    logic [18:0] exp6;

    initial begin
        set_all(8'd0, 8'd0);
        step();
        check("reset_result", 32'(io.result), 32'd0);
        check("reset_busy", 32'(io.busy), 32'd0);
        check("reset_done", 32'(io.done), 32'd0);
        reset_reset = 1'b0;

        // 1: zero operands after reset never start a computation
        run(20, pulses, busy_cycles);
        check("idle_zero_done", 32'(pulses), 32'd0);
        check("idle_zero_busy", 32'(busy_cycles), 32'd0);
        check("idle_zero_result", 32'(io.result), 32'd0);

        // 2: all 0xFF, maximum sum, latency 13, busy 1..12, no partial sums
        set_all(8'hFF, 8'hFF);
        bad = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (!io.busy || io.done || io.result != 19'd0) bad++;
        end
        check("max_busy_window", 32'(bad), 32'd0);
        step();
        check("max_done_c13", 32'(io.done), 32'd1);
        check("max_busy_c13", 32'(io.busy), 32'd0);
        check("max_result", 32'(io.result), 32'd520200);
        step();
        check("max_done_oneshot", 32'(io.done), 32'd0);
        check("max_result_hold", 32'(io.result), 32'd520200);

        // 3: staggered writes every 2 cycles restart the settle window
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            set_op(i, (i < 8) ? 8'(i + 1) : 8'd1);
            if (i != 15) begin
                step(); if (io.done) pulses++;
                step(); if (io.done) pulses++;
            end
        end
        check("stagger_no_early_done", 32'(pulses), 32'd0);
        wait_done(40, cyc);
        check("stagger_latency", 32'(cyc), 32'd13);
        check("stagger_result", 32'(io.result), 32'd36);
        run(20, pulses, busy_cycles);
        check("stagger_single_done", 32'(pulses), 32'd0);

        // 4: change during ACCUM idx=3 finishes old snap, then recomputes
        set_all(8'd1, 8'd1);
        for (int c = 0; c < 8; c++) step();
        set_op(8, 8'd3);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin step(); if (io.done) pulses++; end
        step();
        check("accum_chg_early_done", 32'(pulses), 32'd0);
        check("accum_chg_first_done", 32'(io.done), 32'd1);
        check("accum_chg_first_result", 32'(io.result), 32'd8);
        wait_done(40, cyc);
        check("accum_chg_second_latency", 32'(cyc), 32'd13);
        check("accum_chg_second_result", 32'(io.result), 32'd10);

        // 5: async reset mid-ACCUM, then fresh computation
        set_all(8'd2, 8'd2);
        for (int c = 0; c < 7; c++) step();
        check("midrst_busy_before", 32'(io.busy), 32'd1);
        reset_reset = 1'b1;
        #1;
        check("midrst_result", 32'(io.result), 32'd0);
        check("midrst_busy", 32'(io.busy), 32'd0);
        check("midrst_done", 32'(io.done), 32'd0);
        step();
        reset_reset = 1'b0;
        wait_done(40, cyc);
        check("midrst_latency", 32'(cyc), 32'd13);
        check("midrst_result_after", 32'(io.result), 32'd32);
        run(20, pulses, busy_cycles);
        check("midrst_single_done", 32'(pulses), 32'd0);

        // restoring the snapped value before settle expires still recomputes
        set_op(0, 8'd5);
        step();
        set_op(0, 8'd2);
        wait_done(40, cyc);
        check("restore_latency", 32'(cyc), 32'd13);
        check("restore_result", 32'(io.result), 32'd32);

        // 6: 0x80 * 0x7F, signed or unsigned by build
        set_all(8'h80, 8'h7F);
`ifdef FMA_SIGNED_EN
        exp6 = 19'h60400;
`else
        exp6 = 19'h1FC00;
`endif
        wait_done(40, cyc);
        check("mix_latency", 32'(cyc), 32'd13);
        check("mix_result", 32'(io.result), 32'(exp6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
